// File: rtl/datapath_controller.sv
// Multi-cycle control FSM for the 16-bit register-file/ALU/data-memory datapath.
// Owns PC and IR; decodes each instruction into one execute state per phase.
module datapath_controller #(
  parameter int          PC_W    = 7,
  parameter logic [2:0]  ALU_ADD = 3'd1,
  parameter logic [2:0]  ALU_SUB = 3'd2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     IR_data,
  output logic [PC_W-1:0] PC_out,
  output logic [15:0]     IR_out,
  output logic [3:0]      state_out,
  output logic [7:0]      D_Addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [2:0]      Alu_s0
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        S_INIT:   r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_ir <= IR_data;
          r_pc <= r_pc + PC_W'(1);
          case (IR_data[15:12])
            4'd1:    r_state <= S_STORE;
            4'd2:    r_state <= S_LOAD_A;
            4'd3:    r_state <= S_ADD;
            4'd4:    r_state <= S_SUB;
            4'd5:    r_state <= S_HALT;
            default: r_state <= S_NOOP;
          endcase
        end
        S_LOAD_A: r_state <= S_LOAD_B;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Controls decode from state and the latched IR only, never from IR_data.
  always_comb begin
    D_Addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    Alu_s0     = '0;
    case (r_state)
      S_STORE: begin
        D_Addr     = r_ir[7:0];
        RF_Ra_addr = r_ir[11:8];
        D_wr       = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        D_Addr    = r_ir[7:0];
        RF_s      = 1'b1;
        RF_W_addr = r_ir[11:8];
        RF_W_en   = (r_state == S_LOAD_B);
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = r_ir[11:8];
        RF_Rb_addr = r_ir[7:4];
        Alu_s0     = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_addr  = r_ir[3:0];
        RF_W_en    = 1'b1;
      end
      default: ;
    endcase
  end

  assign PC_out    = r_pc;
  assign IR_out    = r_ir;
  assign state_out = r_state;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller with a behavioural ROM, register file,
// ALU and synchronous-read data memory around it.
module tb_datapath_controller;

  logic        clk;
  logic        reset;
  logic [15:0] IR_data;
  logic [6:0]  PC_out;
  logic [15:0] IR_out;
  logic [3:0]  state_out;
  logic [7:0]  D_Addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  Alu_s0;

  int checks;
  int failures;

  logic [15:0] rom       [128];
  logic [15:0] dmem_init [256];
  logic [15:0] dmem      [256];
  logic [15:0] rf        [16];
  logic [15:0] mem_rd;
  logic [15:0] alu;

  datapath_controller #(.PC_W(7), .ALU_ADD(3'd1), .ALU_SUB(3'd2)) dut (
    .clk(clk), .reset(reset), .IR_data(IR_data), .PC_out(PC_out),
    .IR_out(IR_out), .state_out(state_out), .D_Addr(D_Addr), .D_wr(D_wr),
    .RF_s(RF_s), .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .Alu_s0(Alu_s0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu = 16'h0000;
    if (Alu_s0 == 3'd1) alu = rf[RF_Ra_addr] + rf[RF_Rb_addr];
    else if (Alu_s0 == 3'd2) alu = rf[RF_Ra_addr] - rf[RF_Rb_addr];
  end

  always @(posedge clk) begin
    IR_data <= rom[PC_out];
    mem_rd  <= dmem[D_Addr];
    if (reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= dmem_init[i];
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
    end else begin
      if (D_wr) dmem[D_Addr] <= rf[RF_Ra_addr];
      if (RF_W_en) rf[RF_W_addr] <= RF_s ? mem_rd : alu;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_images();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 256; i++) dmem_init[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_images();
    rom[0] = 16'h2105;
    dmem_init[5] = 16'h0007;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({PC_out, IR_out, state_out, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, Alu_s0} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: pc=%0d ir=%h st=%0d daddr=%h dwr=%b wen=%b required all 0",
                 c, PC_out, IR_out, state_out, D_Addr, D_wr, RF_W_en);
      end
    end
    reset = 1'b0;
    checks++;
    if (state_out !== 4'd0) begin
      failures++; $display("FAIL release_init: state=%0d required 0", state_out);
    end
    step();
    checks++;
    if (state_out !== 4'd1 || PC_out !== 7'd0) begin
      failures++; $display("FAIL release_fetch: state=%0d pc=%0d required 1/0", state_out, PC_out);
    end
    step();
    checks++;
    if (state_out !== 4'd2) begin
      failures++; $display("FAIL release_decode: state=%0d required 2", state_out);
    end
  endtask

  // Continues from the DECODE cycle left by test_reset (ROM[0] = LOAD R1,[5]).
  task automatic test_load();
    step();
    checks++;
    if (state_out !== 4'd4 || D_Addr !== 8'h05 || RF_s !== 1'b1 || RF_W_en !== 1'b0 ||
        PC_out !== 7'd1 || IR_out !== 16'h2105) begin
      failures++;
      $display("FAIL load_a: state=%0d daddr=%h rfs=%b wen=%b pc=%0d ir=%h required 4/05/1/0/1/2105",
               state_out, D_Addr, RF_s, RF_W_en, PC_out, IR_out);
    end
    step();
    checks++;
    if (state_out !== 4'd5 || RF_W_en !== 1'b1 || RF_W_addr !== 4'd1 || RF_s !== 1'b1 ||
        D_Addr !== 8'h05 || D_wr !== 1'b0) begin
      failures++;
      $display("FAIL load_b: state=%0d wen=%b waddr=%0d rfs=%b daddr=%h dwr=%b required 5/1/1/1/05/0",
               state_out, RF_W_en, RF_W_addr, RF_s, D_Addr, D_wr);
    end
    step();
    checks++;
    if (state_out !== 4'd1 || rf[1] !== 16'h0007) begin
      failures++;
      $display("FAIL load_next_fetch: state=%0d r1=%h required 1/0007 four cycles after first fetch",
               state_out, rf[1]);
    end
  endtask

  task automatic test_program();
    bit seen_add, seen_sub, seen_store, halted;
    clear_images();
    rom[0] = 16'h2105; rom[1] = 16'h2206; rom[2] = 16'h3123;
    rom[3] = 16'h4124; rom[4] = 16'h1310; rom[5] = 16'h5000;
    dmem_init[5] = 16'h0007;
    dmem_init[6] = 16'h0003;
    do_reset();
    seen_add = 0; seen_sub = 0; seen_store = 0; halted = 0;
    for (int c = 0; c < 60 && !halted; c++) begin
      step();
      checks++;
      if (D_wr === 1'b1 && RF_W_en === 1'b1) begin
        failures++; $display("FAIL prog_exclusive_en: dwr=1 wen=1 in state %0d", state_out);
      end
      if (state_out == 4'd7) begin
        seen_add = 1;
        checks++;
        if (RF_W_addr !== 4'd3 || Alu_s0 !== 3'd1 || RF_W_en !== 1'b1 || RF_s !== 1'b0 ||
            RF_Ra_addr !== 4'd1 || RF_Rb_addr !== 4'd2) begin
          failures++;
          $display("FAIL prog_add: waddr=%0d alu=%0d wen=%b rfs=%b ra=%0d rb=%0d required 3/1/1/0/1/2",
                   RF_W_addr, Alu_s0, RF_W_en, RF_s, RF_Ra_addr, RF_Rb_addr);
        end
      end
      if (state_out == 4'd8) begin
        seen_sub = 1;
        checks++;
        if (RF_W_addr !== 4'd4 || Alu_s0 !== 3'd2 || RF_W_en !== 1'b1 ||
            RF_Ra_addr !== 4'd1 || RF_Rb_addr !== 4'd2) begin
          failures++;
          $display("FAIL prog_sub: waddr=%0d alu=%0d wen=%b ra=%0d rb=%0d required 4/2/1/1/2",
                   RF_W_addr, Alu_s0, RF_W_en, RF_Ra_addr, RF_Rb_addr);
        end
      end
      if (state_out == 4'd6) begin
        seen_store = 1;
        checks++;
        if (D_wr !== 1'b1 || D_Addr !== 8'h10 || RF_Ra_addr !== 4'd3 || RF_W_en !== 1'b0) begin
          failures++;
          $display("FAIL prog_store: dwr=%b daddr=%h ra=%0d wen=%b required 1/10/3/0",
                   D_wr, D_Addr, RF_Ra_addr, RF_W_en);
        end
      end
      if (state_out == 4'd9) halted = 1;
    end
    checks++;
    if (!(halted && seen_add && seen_sub && seen_store)) begin
      failures++;
      $display("FAIL prog_sequence: halt=%0d add=%0d sub=%0d store=%0d required all 1 within 60 cycles",
               halted, seen_add, seen_sub, seen_store);
    end
    checks++;
    if (dmem[16] !== 16'h000A || rf[4] !== 16'h0004) begin
      failures++;
      $display("FAIL prog_results: mem16=%h r4=%h required 000a/0004", dmem[16], rf[4]);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (state_out !== 4'd9 || PC_out !== 7'd6 || D_wr !== 1'b0 || RF_W_en !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold cycle %0d: state=%0d pc=%0d dwr=%b wen=%b required 9/6/0/0",
                 c, state_out, PC_out, D_wr, RF_W_en);
      end
    end
  endtask

  task automatic test_undefined();
    clear_images();
    rom[0] = 16'hF123;
    rom[1] = 16'h5000;
    do_reset();
    step();
    step();
    step();
    checks++;
    if (state_out !== 4'd3 || D_wr !== 1'b0 || RF_W_en !== 1'b0 || PC_out !== 7'd1 ||
        IR_out !== 16'hF123) begin
      failures++;
      $display("FAIL undef_noop: state=%0d dwr=%b wen=%b pc=%0d ir=%h required 3/0/0/1/f123",
               state_out, D_wr, RF_W_en, PC_out, IR_out);
    end
    step();
    checks++;
    if (state_out !== 4'd1) begin
      failures++; $display("FAIL undef_next_fetch: state=%0d required 1", state_out);
    end
  endtask

  task automatic test_reset_mid_load();
    clear_images();
    rom[0] = 16'h2105;
    do_reset();
    step();
    step();
    step();
    checks++;
    if (state_out !== 4'd4) begin
      failures++; $display("FAIL midload_in_load_a: state=%0d required 4", state_out);
    end
    reset = 1'b1;
    step();
    checks++;
    if (state_out !== 4'd0 || PC_out !== 7'd0 || IR_out !== 16'h0000 || RF_W_en !== 1'b0) begin
      failures++;
      $display("FAIL midload_reset: state=%0d pc=%0d ir=%h wen=%b required 0/0/0000/0",
               state_out, PC_out, IR_out, RF_W_en);
    end
    reset = 1'b0;
  endtask

  task automatic test_pc_wrap();
    int fetches;
    int last_fetch;
    int bad_seq;
    int bad_gap;
    clear_images();
    do_reset();
    fetches = 0; last_fetch = 0; bad_seq = 0; bad_gap = 0;
    for (int c = 0; c < 420 && fetches < 130; c++) begin
      step();
      if (state_out == 4'd1) begin
        if (PC_out !== 7'(fetches % 128)) bad_seq++;
        if (fetches > 0 && c - last_fetch != 3) bad_gap++;
        last_fetch = c;
        fetches++;
      end
    end
    checks++;
    if (fetches != 130 || bad_seq != 0) begin
      failures++;
      $display("FAIL pc_wrap: fetches=%0d bad_pc=%0d required 130/0 (sequence 126,127,0,1)",
               fetches, bad_seq);
    end
    checks++;
    if (bad_gap != 0) begin
      failures++; $display("FAIL noop_cpi: bad_gaps=%0d required 0 (3 cycles)", bad_gap);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    test_reset();
    test_load();
    test_program();
    test_undefined();
    test_reset_mid_load();
    test_pc_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
- Multi-cycle control FSM for the 16-bit register-file/ALU/data-memory datapath.
- Owns the program counter (PC) and instruction register (IR).
- Fetches 16-bit instructions from a synchronous-read instruction ROM, decodes them, and drives every datapath control input (D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0), one execute state per instruction phase.
- Sits between the instruction ROM and the datapath in the processor top level.

Parameters:
PC_W, 7, PC / ROM address width (128-word program)
ALU_ADD, 3'd1, Alu_s0 code for A+B
ALU_SUB, 3'd2, Alu_s0 code for A-B

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
IR_data  in  16  ROM read data; valid the cycle after PC_out is presented
PC_out  out  PC_W  ROM address (current PC)
IR_out  out  16  current instruction register (debug)
state_out  out  4  current FSM state encoding (debug)
D_Addr  out  8  data memory address
D_wr  out  1  data memory write enable
RF_s  out  1  write-data mux select: 0 = ALU, 1 = data memory
RF_W_addr  out  4  register-file write address
RF_W_en  out  1  register-file write enable
RF_Ra_addr  out  4  register-file read port A address
RF_Rb_addr  out  4  register-file read port B address
Alu_s0  out  3  ALU function select

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous, active-high, sampled on the clk rising edge.
- Instruction format is IR[15:12] opcode.
  - 0000 NOOP.
  - 0001 STORE: mem[IR[7:0]] <= RF[IR[11:8]].
  - 0010 LOAD: RF[IR[11:8]] <= mem[IR[7:0]].
  - 0011 ADD: RF[IR[3:0]] <= RF[IR[11:8]] + RF[IR[7:4]].
  - 0100 SUB: RF[IR[3:0]] <= RF[IR[11:8]] - RF[IR[7:4]].
  - 0101 HALT.
  - 0110–1111 are executed as NOOP.
- State encodings: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- Reset (at a rising edge with reset=1, in any state, including mid-LOAD or in HALT):
  - state<=INIT, PC<=0, IR<=16'h0000.
  - Takes precedence over all other updates.
- Output defaults: in every state, all control outputs are 0 unless listed below. Outputs are combinational from state and IR only; there is no IR_data pass-through except at DECODE's IR load.
- INIT: all outputs 0 → FETCH.
- FETCH: PC_out=PC → DECODE.
- DECODE:
  - IR<=IR_data; PC<=PC+1, wrapping from 2^PC_W-1 to 0.
  - Next state is chosen from IR_data[15:12]: NOOP/LOAD_A/STORE/ADD/SUB/HALT.
- NOOP: → FETCH.
- STORE:
  - D_Addr=IR[7:0], RF_Ra_addr=IR[11:8], D_wr=1 → FETCH.
- LOAD_A:
  - D_Addr=IR[7:0], RF_s=1, RF_W_addr=IR[11:8], RF_W_en=0 (memory read latency cycle) → LOAD_B.
- LOAD_B:
  - Same D_Addr, RF_s and RF_W_addr, with RF_W_en=1 → FETCH.
- ADD:
  - RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], Alu_s0=ALU_ADD, RF_s=0, RF_W_addr=IR[3:0], RF_W_en=1 → FETCH.
- SUB: as ADD with Alu_s0=ALU_SUB.
- HALT: all controls 0; PC frozen; remains in HALT until reset.
- Cycles per instruction, measured FETCH to next FETCH:
  - NOOP/STORE/ADD/SUB: 3.
  - LOAD: 4.
  - HALT: terminal.
- Invariants:
  - D_wr and RF_W_en are never both 1 in the same cycle.
  - RF_W_en is never 1 outside LOAD_B/ADD/SUB.
  - PC changes only in DECODE.

Test Plan:
- Hold reset 2 cycles, then release:
  - During reset, all outputs are 0.
  - After release: state_out 0 → 1 → 2.
  - PC_out=0 in FETCH; PC becomes 1 after DECODE.
- ROM[0]=16'h2105 (LOAD R1,mem[5]) with mem[5]=16'h0007:
  - LOAD_A: D_Addr=8'h05, RF_s=1, RF_W_en=0.
  - LOAD_B: RF_W_en=1, RF_W_addr=1.
  - Next FETCH occurs 4 cycles after the first.
- Program LOAD R1,[5]; LOAD R2,[6] (mem[6]=16'h0003); ADD 16'h3123; SUB 16'h4124; STORE 16'h1310; HALT:
  - ADD state: RF_W_addr=3, Alu_s0=1, RF_W_en=1.
  - SUB state: RF_W_addr=4, Alu_s0=2, RF_W_en=1.
  - Store state: D_wr=1, D_Addr=8'h10, Ra=3; afterwards mem[16]=16'h000A.
  - Then HALT for 20 cycles with PC_out frozen at 6 and no enables.
- ROM[0]=16'hF123 (undefined opcode): passes through NOOP state 3, no enables asserted, PC=1, next FETCH after 3 cycles.
- Assert reset during LOAD_A:
  - LOAD_B never occurs and RF_W_en stays 0.
  - Next cycle state=INIT, PC=0, IR=0.
- ROM filled with NOOP, run 128 instructions: PC wraps from 127 to 0; PC_out sequence continues 126, 127, 0, 1.
